// File: rtl/chip7458_tester.sv
// chip7458_tester: built-in self-test engine for a chip7458 AND-OR block.
// Sweeps all 1024 input combinations, waits a settle window per vector,
// compares p1y/p2y against the golden AND-OR response, and reports a
// saturating mismatch count plus the first failing vector index.
module chip7458_tester #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             p1a,
   output logic             p1b,
   output logic             p1c,
   output logic             p1d,
   output logic             p1e,
   output logic             p1f,
   output logic             p2a,
   output logic             p2b,
   output logic             p2c,
   output logic             p2d,
   input  logic             p1y,
   input  logic             p2y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_seen,
   output logic [9:0]       first_fail_vec
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [9:0]       VEC_LAST    = 10'h3FF;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [9:0]       vec;
   logic [CNT_W-1:0] settle_cnt;

   // Control strobes decoded from the current state.
   logic             launch;
   logic             cnt_inc;
   logic             checking;
   logic             advance;
   logic             finish;

   logic             exp1;
   logic             exp2;
   logic             mismatch;
   logic [ERR_W-1:0] err_next;

   // Stimulus comes straight from the vector register, so it is glitch-free.
   assign {p2d, p2c, p2b, p2a, p1f, p1e, p1d, p1c, p1b, p1a} = vec;

   // Golden AND-OR response for the vector currently applied.
   assign exp1     = (vec[0] & vec[1] & vec[2]) | (vec[3] & vec[4] & vec[5]);
   assign exp2     = (vec[6] & vec[7]) | (vec[8] & vec[9]);
   // A vector failing on both outputs still counts as a single error.
   assign mismatch = (p1y != exp1) | (p2y != exp2);

   // Error count including the check happening this cycle; sticks at all-ones.
   always_comb begin
      err_next = err_count;
      if (checking && mismatch && (err_count != {ERR_W{1'b1}}))
         err_next = err_count + ERR_W'(1);
   end

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of the order the blocks are evaluated in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and control-strobe decode; start is only honoured when idle or done.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_next = state;
      launch     = 1'b0;
      cnt_inc    = 1'b0;
      checking   = 1'b0;
      advance    = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               launch     = 1'b1;
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt == SETTLE_LAST) state_next = CHECK;
            else                           cnt_inc    = 1'b1;
         end
         CHECK: begin
            checking = 1'b1;
            if (vec == VEC_LAST) begin
               finish     = 1'b1;
               state_next = DONE;
            end else begin
               advance    = 1'b1;
               state_next = SETTLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Sweep datapath: vector, settle counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec            <= '0;
         settle_cnt     <= '0;
         err_count      <= '0;
         fail_seen      <= 1'b0;
         first_fail_vec <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
      end else begin
         if (launch) begin
            vec            <= '0;
            settle_cnt     <= '0;
            err_count      <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
         end else if (cnt_inc) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
         end

         if (checking) begin
            err_count <= err_next;
            if (mismatch && !fail_seen) begin
               first_fail_vec <= vec;
               fail_seen      <= 1'b1;
            end
         end

         if (advance) begin
            vec        <= vec + 10'd1;
            settle_cnt <= '0;
         end

         if (finish) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_chip7458_tester.sv
// Directed bench for chip7458_tester: a behavioural chip7458 with selectable
// stuck-output faults feeds the main instance; a second instance with a
// 4-bit error counter always sees p2y stuck high to exercise saturation.
module tb_chip7458_tester;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   int          fault;           // 0 none, 1 p1y stuck 0, 2 p2y stuck 1

   logic        p1a, p1b, p1c, p1d, p1e, p1f, p2a, p2b, p2c, p2d;
   logic        p1y, p2y;
   logic        busy, done, pass, fail_seen;
   logic [10:0] err_count;
   logic [9:0]  first_fail_vec;

   logic        q1a, q1b, q1c, q1d, q1e, q1f, q2a, q2b, q2c, q2d;
   logic        q1y;
   logic        busy4, done4, pass4, fail_seen4;
   logic [3:0]  err_count4;
   logic [9:0]  first_fail_vec4;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cycles;

   always #5 clk = ~clk;

   // Behavioural chip7458 with optional stuck-at faults on the outputs.
   assign p1y = (fault == 1) ? 1'b0 : ((p1a & p1b & p1c) | (p1d & p1e & p1f));
   assign p2y = (fault == 2) ? 1'b1 : ((p2a & p2b) | (p2c & p2d));
   assign q1y = (q1a & q1b & q1c) | (q1d & q1e & q1f);

   chip7458_tester #(.SETTLE_CYCLES(2), .ERR_W(11)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .p1a(p1a), .p1b(p1b), .p1c(p1c), .p1d(p1d), .p1e(p1e), .p1f(p1f),
      .p2a(p2a), .p2b(p2b), .p2c(p2c), .p2d(p2d),
      .p1y(p1y), .p2y(p2y),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_seen(fail_seen), .first_fail_vec(first_fail_vec)
   );

   chip7458_tester #(.SETTLE_CYCLES(2), .ERR_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .p1a(q1a), .p1b(q1b), .p1c(q1c), .p1d(q1d), .p1e(q1e), .p1f(q1f),
      .p2a(q2a), .p2b(q2b), .p2c(q2c), .p2d(q2d),
      .p1y(q1y), .p2y(1'b1),
      .busy(busy4), .done(done4), .pass(pass4), .err_count(err_count4),
      .fail_seen(fail_seen4), .first_fail_vec(first_fail_vec4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Pulse start, then count edges after the start edge until done is seen.
   // mid_start > 0 raises start again for one cycle at that point of the sweep.
   task automatic run_sweep(input int mid_start, output int n);
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1;
      check("busy_after_start", busy, 1);
      check("done_cleared", done, 0);
      @(negedge clk) start = 1'b0;
      n = 0;
      while (n < 5000) begin
         @(posedge clk); n++; #1;
         if (n == mid_start)     start = 1'b1;
         if (n == mid_start + 1) start = 1'b0;
         if (done) break;
      end
      if (!done) check("done_timeout", n, 3072);
   endtask

   function automatic logic [9:0] stim();
      return {p2d, p2c, p2b, p2a, p1f, p1e, p1d, p1c, p1b, p1a};
   endfunction

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      fault = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_count, 0);
      check("rst_stim", stim(), 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Fault-free sweep.
      run_sweep(0, cycles);
      check("clean_cycles", cycles, 3072);
      check("clean_busy", busy, 0);
      check("clean_pass", pass, 1);
      check("clean_err", err_count, 0);
      check("clean_fail_seen", fail_seen, 0);
      check("done_stim_held", stim(), 10'h3FF);
      repeat (5) @(posedge clk);
      #1;
      check("done_held", done, 1);

      // p1y stuck at 0, restarted directly from DONE.
      fault = 1;
      run_sweep(0, cycles);
      check("p1y0_cycles", cycles, 3072);
      check("p1y0_err", err_count, 240);
      check("p1y0_first", first_fail_vec, 10'h007);
      check("p1y0_fail_seen", fail_seen, 1);
      check("p1y0_pass", pass, 0);

      // p2y stuck at 1; start pulse mid-sweep must not disturb timing.
      fault = 2;
      run_sweep(1500, cycles);
      check("p2y1_cycles_midstart", cycles, 3072);
      check("p2y1_err", err_count, 576);
      check("p2y1_first", first_fail_vec, 10'h000);
      check("p2y1_pass", pass, 0);
      check("sat_done", done4, 1);
      check("sat_err", err_count4, 15);
      check("sat_pass", pass4, 0);
      check("sat_first", first_fail_vec4, 10'h000);

      // Repeat from DONE: identical result expected.
      run_sweep(0, cycles);
      check("rerun_cycles", cycles, 3072);
      check("rerun_err", err_count, 576);
      check("rerun_first", first_fail_vec, 10'h000);

      // Asynchronous reset mid-sweep (around vector 300), then a clean sweep.
      fault = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (900) @(posedge clk);
      #2;
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_err", err_count, 0);
      check("arst_fail_seen", fail_seen, 0);
      check("arst_first", first_fail_vec, 0);
      check("arst_stim", stim(), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_after_rst", busy, 0);
      run_sweep(0, cycles);
      check("post_rst_cycles", cycles, 3072);
      check("post_rst_pass", pass, 1);
      check("post_rst_err", err_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
